// File: rtl/ysyx_220053_hazard_ctrl.sv
// ysyx_220053_hazard_ctrl
// Central sequencer for the 5-stage IF/ID/EX/M/WB pipeline. Produces the
// PC enable, per-stage register enables/flushes and the operand-forwarding
// selects, and tracks multi-cycle stalls (data-memory wait, MUL/DIV) with a
// four-state FSM (BOOT, RUN, MEM_WAIT, MUL_WAIT).
//
// Parameters:
//   REG_AW   register-address width
//   BOOT_CYC flush cycles issued after reset release (1..15)
//
// Ports:
//   clk, rst (asynchronous, active-low)
//   if_valid                       fetched instruction available
//   id_rs1/id_rs2, id_use_rs1/2    ID source registers and their use bits
//   id_redirect                    ID resolved a taken control transfer
//   ex_rd/ex_wen/ex_memtoreg       EX writer (ex_memtoreg = load)
//   ex_mul_start, mul_done         multi-cycle MUL/DIV handshake
//   m_rd/m_wen, m_memreq/m_memack  M writer and data-memory handshake
//   wb_rd/wb_wen                   WB writer
//   pc_en, *_en, *_flush           stage control (flush overrides enable)
//   fwd_a/fwd_b                    00 regfile, 01 EX, 10 M, 11 WB
//
// Build option: define HAZARD_FWD_EN to enable operand forwarding. Without
// it the forwarding selects stay 00 and any RAW dependency on an in-flight
// writer (EX, M or WB) stalls ID until the writer has retired.
module ysyx_220053_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int BOOT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_redirect,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_wen,
  input  logic              ex_memtoreg,
  input  logic              ex_mul_start,
  input  logic              mul_done,
  input  logic [REG_AW-1:0] m_rd,
  input  logic              m_wen,
  input  logic              m_memreq,
  input  logic              m_memack,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_wen,
  output logic              pc_en,
  output logic              id_en,
  output logic              ex_en,
  output logic              m_en,
  output logic              wb_en,
  output logic              id_flush,
  output logic              ex_flush,
  output logic              m_flush,
  output logic              wb_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  typedef enum logic [1:0] {BOOT, RUN, MEM_WAIT, MUL_WAIT} state_t;
  // Action chosen for the current cycle; shared by next-state and output logic.
  typedef enum logic [2:0] {
    ACT_BOOT, ACT_FREE, ACT_MEM, ACT_MUL, ACT_RAW, ACT_REDIR, ACT_NOFETCH
  } act_t;

  state_t     state_reg, state_next;
  logic [3:0] boot_cnt_reg, boot_cnt_next;
  logic       mul_sticky_reg, mul_sticky_next;
  act_t       act;

  // Source operand hit detection against each in-flight writer.
  logic [REG_AW-1:0] src [2];
  logic [1:0]        use_src;
  logic [1:0]        hit_ex, hit_m, hit_wb;

  assign src[0]  = id_rs1;
  assign src[1]  = id_rs2;
  assign use_src = {id_use_rs2, id_use_rs1};

`ifdef HAZARD_FWD_EN
  logic [1:0] fwd_sel [2];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic live;
      // x0 is never a dependency.
      assign live       = use_src[gi] & (src[gi] != '0);
      assign hit_ex[gi] = live & ex_wen & (ex_rd == src[gi]);
      assign hit_m[gi]  = live & m_wen  & (m_rd  == src[gi]);
      assign hit_wb[gi] = live & wb_wen & (wb_rd == src[gi]);
`ifdef HAZARD_FWD_EN
      // A load in EX has no data yet, so it cannot feed the EX bypass.
      assign fwd_sel[gi] = (hit_ex[gi] & ~ex_memtoreg) ? 2'b01 :
                           hit_m[gi]                   ? 2'b10 :
                           hit_wb[gi]                  ? 2'b11 : 2'b00;
`endif
    end
  endgenerate

  logic load_use, raw_stall, mem_stall, mul_stall, mul_done_eff;

  assign load_use = ex_memtoreg & (|hit_ex);
`ifdef HAZARD_FWD_EN
  assign raw_stall = load_use;
`else
  assign raw_stall = load_use | (|hit_ex) | (|hit_m) | (|hit_wb);
`endif
  assign mem_stall    = m_memreq & ~m_memack;
  // mul_done seen while the pipe was frozen counts as done.
  assign mul_done_eff = mul_done | mul_sticky_reg;
  assign mul_stall    = ex_mul_start & ~mul_done_eff;

  // Action decode. MEM_WAIT holds until ack regardless of m_memreq; the ack
  // cycle (and every MUL_WAIT cycle) falls through to the normal priority
  // chain, which naturally re-enters MUL_WAIT if the multiply is not done.
  always_comb begin
    act = ACT_FREE;
    if (state_reg == BOOT)                       act = ACT_BOOT;
    else if (state_reg == MEM_WAIT && !m_memack) act = ACT_MEM;
    else if (mem_stall)                          act = ACT_MEM;
    else if (mul_stall)                          act = ACT_MUL;
    else if (raw_stall)                          act = ACT_RAW;
    else if (id_redirect)                        act = ACT_REDIR;
    else if (!if_valid)                          act = ACT_NOFETCH;
    else                                         act = ACT_FREE;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= BOOT;
      boot_cnt_reg   <= 4'(BOOT_CYC);
      mul_sticky_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      boot_cnt_reg   <= boot_cnt_next;
      mul_sticky_reg <= mul_sticky_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next      = state_reg;
    boot_cnt_next   = boot_cnt_reg;
    mul_sticky_next = 1'b0;
    case (act)
      ACT_BOOT: begin
        boot_cnt_next = boot_cnt_reg - 4'd1;
        if (boot_cnt_reg <= 4'd1) state_next = RUN;
      end
      ACT_MEM: begin
        state_next      = MEM_WAIT;
        mul_sticky_next = mul_sticky_reg | (ex_mul_start & mul_done);
      end
      ACT_MUL: begin
        state_next      = MUL_WAIT;
        mul_sticky_next = mul_sticky_reg | (ex_mul_start & mul_done);
      end
      default: state_next = RUN;
    endcase
  end

  // Output logic.
  always_comb begin
    pc_en    = 1'b1;
    id_en    = 1'b1;
    ex_en    = 1'b1;
    m_en     = 1'b1;
    wb_en    = 1'b1;
    id_flush = 1'b0;
    ex_flush = 1'b0;
    m_flush  = 1'b0;
    wb_flush = 1'b0;
    case (act)
      ACT_BOOT: begin
        pc_en    = 1'b0;
        id_flush = 1'b1;
        ex_flush = 1'b1;
        m_flush  = 1'b1;
        wb_flush = 1'b1;
      end
      ACT_MEM: begin
        pc_en    = 1'b0;
        id_en    = 1'b0;
        ex_en    = 1'b0;
        m_en     = 1'b0;
        wb_flush = 1'b1;
      end
      ACT_MUL: begin
        pc_en   = 1'b0;
        id_en   = 1'b0;
        ex_en   = 1'b0;
        m_flush = 1'b1;
      end
      ACT_RAW: begin
        pc_en    = 1'b0;
        id_en    = 1'b0;
        ex_flush = 1'b1;
      end
      ACT_REDIR: id_flush = 1'b1;
      ACT_NOFETCH: begin
        pc_en    = 1'b0;
        id_flush = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef HAZARD_FWD_EN
  assign fwd_a = (state_reg == BOOT) ? 2'b00 : fwd_sel[0];
  assign fwd_b = (state_reg == BOOT) ? 2'b00 : fwd_sel[1];
`else
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

endmodule

// File: tb/tb_ysyx_220053_hazard_ctrl.sv
// Directed bench for ysyx_220053_hazard_ctrl (BOOT_CYC=2). Single-cycle RUN
// behaviour is table-driven; boot, memory/multiply waits and reset during a
// stall are hand-written sequences. Output word layout:
// {pc_en, id_en, ex_en, m_en, wb_en, id_flush, ex_flush, m_flush, wb_flush,
//  fwd_a, fwd_b}.
module tb_ysyx_220053_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       if_valid, id_use_rs1, id_use_rs2, id_redirect;
  logic [4:0] id_rs1, id_rs2, ex_rd, m_rd, wb_rd;
  logic       ex_wen, ex_memtoreg, ex_mul_start, mul_done;
  logic       m_wen, m_memreq, m_memack, wb_wen;
  logic       pc_en, id_en, ex_en, m_en, wb_en;
  logic       id_flush, ex_flush, m_flush, wb_flush;
  logic [1:0] fwd_a, fwd_b;

  ysyx_220053_hazard_ctrl #(.REG_AW(5), .BOOT_CYC(2)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_redirect(id_redirect),
    .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_memtoreg(ex_memtoreg),
    .ex_mul_start(ex_mul_start), .mul_done(mul_done),
    .m_rd(m_rd), .m_wen(m_wen), .m_memreq(m_memreq), .m_memack(m_memack),
    .wb_rd(wb_rd), .wb_wen(wb_wen),
    .pc_en(pc_en), .id_en(id_en), .ex_en(ex_en), .m_en(m_en), .wb_en(wb_en),
    .id_flush(id_flush), .ex_flush(ex_flush), .m_flush(m_flush),
    .wb_flush(wb_flush), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [12:0] ALL_EN  = 13'b1_1111_0000_00_00;
  localparam logic [12:0] BOOT_O  = 13'b0_1111_1111_00_00;
  localparam logic [12:0] MEM_O   = 13'b0_0001_0001_00_00;
  localparam logic [12:0] MUL_O   = 13'b0_0011_0010_00_00;
  localparam logic [12:0] RAW_O   = 13'b0_0111_0100_00_00;
  localparam logic [12:0] REDIR_O = 13'b1_1111_1000_00_00;
  localparam logic [12:0] NOF_O   = 13'b0_1111_1000_00_00;

  typedef struct {
    string       name;
    logic        ifv;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic        redir;
    logic [4:0]  exrd;
    logic        exw;
    logic        exld;
    logic [4:0]  mrd;
    logic        mw;
    logic [4:0]  wbrd;
    logic        wbw;
    logic [12:0] exp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t vecs [14];

  function automatic vec_t mk(string n, logic ifv, logic [4:0] rs1, logic u1,
                              logic [4:0] rs2, logic u2, logic redir,
                              logic [4:0] exrd, logic exw, logic exld,
                              logic [4:0] mrd, logic mw, logic [4:0] wbrd,
                              logic wbw, logic [12:0] exp);
    vec_t v;
    v.name = n; v.ifv = ifv; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.redir = redir; v.exrd = exrd; v.exw = exw; v.exld = exld;
    v.mrd = mrd; v.mw = mw; v.wbrd = wbrd; v.wbw = wbw; v.exp = exp;
    return v;
  endfunction

  task automatic idle();
    if_valid = 1'b1; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0;
    id_use_rs2 = 1'b0; id_redirect = 1'b0; ex_rd = '0; ex_wen = 1'b0;
    ex_memtoreg = 1'b0; ex_mul_start = 1'b0; mul_done = 1'b0; m_rd = '0;
    m_wen = 1'b0; m_memreq = 1'b0; m_memack = 1'b0; wb_rd = '0; wb_wen = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    idle();
    if_valid = v.ifv; id_rs1 = v.rs1; id_use_rs1 = v.u1; id_rs2 = v.rs2;
    id_use_rs2 = v.u2; id_redirect = v.redir; ex_rd = v.exrd; ex_wen = v.exw;
    ex_memtoreg = v.exld; m_rd = v.mrd; m_wen = v.mw; wb_rd = v.wbrd;
    wb_wen = v.wbw;
  endtask

  task automatic chk(input string name, input logic [12:0] exp);
    logic [12:0] got;
    #2;
    got = {pc_en, id_en, ex_en, m_en, wb_en, id_flush, ex_flush, m_flush,
           wb_flush, fwd_a, fwd_b};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", name, got, exp);
    end else begin
      $display("ok   %s out %b", name, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = mk("free",          1, 0,1, 0,0, 0, 0,0,0, 0,0, 0,0, ALL_EN);
    vecs[1]  = mk("no_fetch",      0, 0,0, 0,0, 0, 0,0,0, 0,0, 0,0, NOF_O);
    vecs[2]  = mk("redirect",      1, 0,0, 0,0, 1, 0,0,0, 0,0, 0,0, REDIR_O);
    vecs[3]  = mk("redir_nofetch", 0, 0,0, 0,0, 1, 0,0,0, 0,0, 0,0, REDIR_O);
    vecs[4]  = mk("load_use_rs1",  1, 5,1, 1,1, 0, 5,1,1, 0,0, 0,0, RAW_O);
    vecs[5]  = mk("load_rs2_unused",1, 1,1, 5,0, 0, 5,1,1, 0,0, 0,0, ALL_EN);
    vecs[6]  = mk("load_x0",       1, 0,1, 0,1, 0, 0,1,1, 0,0, 0,0, ALL_EN);
    vecs[7]  = mk("ex_over_m_rs2", 1, 0,1, 3,1, 0, 3,1,0, 3,1, 0,0,
                  FWD ? (ALL_EN | 13'b00_01) : RAW_O);
    vecs[8]  = mk("m_rs1",         1, 5,1, 0,0, 0, 0,0,0, 5,1, 0,0,
                  FWD ? (ALL_EN | 13'b10_00) : RAW_O);
    vecs[9]  = mk("wb_both",       1, 9,1, 9,1, 0, 0,0,0, 0,0, 9,1,
                  FWD ? (ALL_EN | 13'b11_11) : RAW_O);
    vecs[10] = mk("m_over_wb",     1, 4,1, 0,0, 0, 0,0,0, 4,1, 4,1,
                  FWD ? (ALL_EN | 13'b10_00) : RAW_O);
    vecs[11] = mk("load_use_redir",1, 5,1, 0,0, 1, 5,1,1, 0,0, 0,0, RAW_O);
    vecs[12] = mk("wb_no_wen",     1, 6,1, 6,1, 0, 0,0,0, 0,0, 6,0, ALL_EN);
    vecs[13] = mk("ex_x0_writer",  1, 0,1, 0,1, 0, 0,1,0, 0,0, 0,0, ALL_EN);

    // Reset and boot: two flush cycles then free running.
    idle();
    rst = 1'b1;
    #1 rst = 1'b0;
    chk("reset_state", BOOT_O);
    tick();
    rst = 1'b1;
    chk("boot_cyc0", BOOT_O);
    tick();
    chk("boot_cyc1", BOOT_O);
    tick();
    chk("boot_done", ALL_EN);
    tick();

    for (int i = 0; i < 14; i++) begin
      apply(vecs[i]);
      chk(vecs[i].name, vecs[i].exp);
      tick();
    end

    // Load-use: lw x5 in EX, add x6,x5,x1 in ID, then load moves to M.
    idle();
    ex_rd = 5; ex_wen = 1; ex_memtoreg = 1; id_rs1 = 5; id_use_rs1 = 1;
    id_rs2 = 1; id_use_rs2 = 1;
    chk("lu_stall", RAW_O);
    tick();
    ex_rd = 0; ex_wen = 0; ex_memtoreg = 0; m_rd = 5; m_wen = 1;
    chk("lu_after", FWD ? (ALL_EN | 13'b10_00) : RAW_O);
    tick();

    // M writes x7, ID reads x7; writer retires over two cycles.
    idle();
    m_rd = 7; m_wen = 1; id_rs1 = 7; id_use_rs1 = 1;
    chk("raw_m_x7", FWD ? (ALL_EN | 13'b10_00) : RAW_O);
    tick();
    m_wen = 0; m_rd = 0; wb_rd = 7; wb_wen = 1;
    chk("raw_wb_x7", FWD ? (ALL_EN | 13'b11_00) : RAW_O);
    tick();
    wb_wen = 0; wb_rd = 0;
    chk("raw_retired", ALL_EN);
    tick();

    // Memory wait: ack on the 5th cycle.
    idle();
    m_memreq = 1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("mem_wait%0d", c), MEM_O);
      tick();
    end
    m_memack = 1;
    chk("mem_ack", ALL_EN);
    tick();
    idle();
    chk("mem_after", ALL_EN);
    tick();

    // Ack in the request cycle never enters MEM_WAIT.
    m_memreq = 1; m_memack = 1;
    chk("mem_same_ack", ALL_EN);
    tick();
    idle();
    chk("mem_same_after", ALL_EN);
    tick();

    // Multiply with a pending redirect: redirect honoured only on release.
    idle();
    ex_mul_start = 1; id_redirect = 1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("mul_wait%0d", c), MUL_O);
      tick();
    end
    mul_done = 1;
    chk("mul_release", REDIR_O);
    tick();
    idle();
    chk("mul_after", ALL_EN);
    tick();

    // Multiply interrupted by memory wait; mul_done seen during the wait.
    ex_mul_start = 1;
    chk("mm_mul", MUL_O);
    tick();
    m_memreq = 1;
    chk("mm_mem0", MEM_O);
    tick();
    mul_done = 1;
    chk("mm_mem_done", MEM_O);
    tick();
    mul_done = 0; m_memack = 1;
    chk("mm_ack_sticky", ALL_EN);
    tick();
    idle();
    chk("mm_after", ALL_EN);
    tick();

    // Multiply interrupted by memory wait; mul still busy at ack.
    ex_mul_start = 1;
    chk("mb_mul", MUL_O);
    tick();
    m_memreq = 1;
    chk("mb_mem", MEM_O);
    tick();
    m_memack = 1;
    chk("mb_ack_busy", MUL_O);
    tick();
    m_memreq = 0; m_memack = 0;
    chk("mb_mul_again", MUL_O);
    tick();
    mul_done = 1;
    chk("mb_done", ALL_EN);
    tick();
    idle();
    chk("mb_after", ALL_EN);
    tick();

    // Reset asserted in the middle of a memory wait.
    m_memreq = 1;
    chk("rs_mem0", MEM_O);
    tick();
    chk("rs_mem1", MEM_O);
    #1 rst = 1'b0;
    chk("rs_reset", BOOT_O);
    tick();
    idle();
    rst = 1'b1;
    chk("rs_boot0", BOOT_O);
    tick();
    chk("rs_boot1", BOOT_O);
    tick();
    chk("rs_run", ALL_EN);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_220053_hazard_ctrl.md
Name: ysyx_220053_hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage IF/ID/EX/M/WB core.
- Generates per-stage enable/flush, PC enable and operand-forwarding selects.
- Tracks multi-cycle stalls (data-memory wait, multi-cycle MUL/DIV) with a small FSM.
- Replaces the hardwired valid/enable assigns in the core top.

Parameters:
REG_AW, 5, register-address width
BOOT_CYC, 1, flush cycles issued after reset release (1..15)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-low
if_valid  in  1  IFU has a fetched instruction this cycle
id_rs1  in  REG_AW  ID source 1
id_rs2  in  REG_AW  ID source 2
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
id_redirect  in  1  ID resolved taken branch/jump/ecall/mret
ex_rd  in  REG_AW  EX destination
ex_wen  in  1  EX writes regfile
ex_memtoreg  in  1  EX is a load
ex_mul_start  in  1  EX holds multi-cycle MUL/DIV
mul_done  in  1  multiplier result ready
m_rd  in  REG_AW  M destination
m_wen  in  1  M writes regfile
m_memreq  in  1  M issues data-memory access
m_memack  in  1  data memory done
wb_rd  in  REG_AW  WB destination
wb_wen  in  1  WB writes regfile
pc_en  out  1  PC update enable
id_en, ex_en, m_en, wb_en  out  1 each  stage-register enables
id_flush, ex_flush, m_flush, wb_flush  out  1 each  insert bubble into stage register
fwd_a  out  2  busa select: 00 regfile, 01 EX, 10 M, 11 WB
fwd_b  out  2  busb select, same encoding

Behaviour:
- flush overrides enable at the stage register (register loads invalid bubble).
- FSM states: BOOT, RUN, MEM_WAIT, MUL_WAIT. Reset (async, rst=0) -> BOOT, boot counter = BOOT_CYC.
- BOOT: all flushes=1, pc_en=0, all enables=1, fwd=00; counter decrements each cycle; at 1 -> RUN.
- RUN, evaluated in priority order (first match wins, same cycle, combinational on inputs):
  1. m_memreq & ~m_memack: pc_en=id_en=ex_en=m_en=0, wb_flush=1; next MEM_WAIT.
  2. ex_mul_start & ~mul_done: pc_en=id_en=ex_en=0, m_flush=1; next MUL_WAIT.
  3. load-use: ex_memtoreg & ex_wen & ex_rd!=0 & ((id_use_rs1 & rs1==ex_rd) | (id_use_rs2 & rs2==ex_rd)): pc_en=id_en=0, ex_flush=1; one cycle only, stay RUN.
  4. id_redirect: id_flush=1, pc_en=1 (wrong-path fetch killed); redirect never honoured in a stall cycle (ID held, redirect re-presented).
  5. ~if_valid: pc_en=0, id_flush=1.
  6. else all enables=1, flushes=0.
- Redirect and ~if_valid together: id_flush=1, pc_en=1.
- MEM_WAIT: same outputs as rule 1 until m_memack=1; ack cycle: all enables=1, -> RUN. Ack in the request cycle never enters MEM_WAIT.
- MUL_WAIT: outputs of rule 2 unless a memory wait starts (rule 1 wins, mul state kept: return to MUL_WAIT after ack if mul_done not yet seen; mul_done latched in a sticky bit while waiting).
- Forwarding (rs1→fwd_a, rs2→fwd_b): match requires src!=0 and use bit; EX (ex_wen & ~ex_memtoreg) > M (m_wen) > WB (wb_wen) > regfile. Never forwards x0.
- Reset mid-stall: FSM and sticky bit cleared immediately, BOOT restarts.

Optional Feature:
HAZARD_FWD_EN
- Defined: forwarding as above; only load-use/mem/mul stall.
- Undefined: fwd_a=fwd_b=00 always; rule 3 widens to any RAW match against EX, M or WB writer (wen, rd!=0), stalling until the writer has retired past WB.

Test Plan:
- Reset release with BOOT_CYC=2 -> 2 cycles of all flushes=1, pc_en=0, then RUN with all enables=1.
- ex: lw x5 (ex_memtoreg=1, ex_rd=5), id: add x6,x5,x1 -> one cycle pc_en=0,id_en=0,ex_flush=1; next cycle fwd_a=10.
- add x3 in EX, M also writes x3, id uses rs2=3 -> fwd_b=01; rs1=0 with ex_rd=0 -> fwd_a=00.
- m_memreq=1, ack after 4 cycles -> 4 cycles wb_flush=1, pc/id/ex/m_en=0; 5th cycle all enables=1.
- ex_mul_start, mul_done after 3 cycles while id_redirect=1 -> m_flush for 3 cycles, id_flush only in the release cycle.
- HAZARD_FWD_EN undefined: M writes x7, id reads x7 -> stall 2 cycles, fwd=00 throughout.
